// File: rtl/mem_event_sequencer.sv
// Interrupt/exception entry sequencer for the memory stage. It shares the single DATA_MEM
// port with the pipeline, pushes return state on the stack and fetches the handler vector.
module mem_event_sequencer #(
    parameter logic [31:0] IRQ_VEC      = 32'h0000_0002,
    parameter logic [31:0] EXC_VEC_BASE = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_irq,
    input  logic        i_irq_en,
    input  logic [1:0]  i_exc,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_flags,
    input  logic [31:0] i_sp,
    input  logic        i_pipe_mem_en,
    input  logic        i_pipe_read,
    input  logic        i_pipe_write,
    input  logic        i_pipe_en32,
    input  logic [31:0] i_pipe_addr,
    input  logic [31:0] i_pipe_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_mem_en32,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_sp_dec,
    output logic        o_pc_load,
    output logic [31:0] o_pc_target,
    output logic [31:0] o_epc,
    output logic        o_irq_ack,
    output logic        o_busy
);

    typedef enum logic [2:0] {StIdle, StDrain, StPush, StVec, StLoad} state_e;
    typedef enum logic {KindIrq, KindExc} kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_target_q, pc_target_d;

    logic        exc_hit;
    logic [1:0]  cause_m1;
    logic [31:0] vec_addr;
    logic        mem_write_raw;
    logic        sp_dec_raw;

    assign exc_hit  = (i_exc != 2'b00);
    assign cause_m1 = cause_q - 2'd1;
    assign vec_addr = (kind_q == KindIrq) ? IRQ_VEC
                                          : EXC_VEC_BASE + {29'd0, cause_m1, 1'b0};

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cause_d     = cause_q;
        ret_d       = ret_q;
        epc_d       = epc_q;
        pc_target_d = pc_target_q;
        unique case (state_q)
            StIdle: begin
                if (exc_hit) begin
                    cause_d = i_exc;
                    epc_d   = i_pc;
                    kind_d  = KindExc;
                    state_d = StVec;
                end else if (i_irq && i_irq_en) begin
                    ret_d   = i_pc;
                    kind_d  = KindIrq;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The IRQ is level-sensitive, so dropping it here just defers it.
                if (exc_hit) begin
                    cause_d = i_exc;
                    epc_d   = i_pc;
                    kind_d  = KindExc;
                    state_d = StVec;
                end else if (!i_pipe_mem_en) begin
                    state_d = StPush;
                end
            end
            StPush: begin
                if (exc_hit) begin
                    cause_d = i_exc;
                    epc_d   = ret_q;
                    kind_d  = KindExc;
                end
                state_d = StVec;
            end
            StVec: begin
                pc_target_d = i_mem_rdata;
                state_d     = StLoad;
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            kind_q      <= KindIrq;
            cause_q     <= 2'b00;
            ret_q       <= 32'd0;
            epc_q       <= 32'd0;
            pc_target_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cause_q     <= cause_d;
            ret_q       <= ret_d;
            epc_q       <= epc_d;
            pc_target_q <= pc_target_d;
        end
    end

    always_comb begin
        o_mem_addr    = 32'd0;
        o_mem_wdata   = 32'd0;
        o_mem_read    = 1'b0;
        mem_write_raw = 1'b0;
        o_mem_en32    = 1'b0;
        o_stall       = 1'b0;
        o_flush       = 1'b0;
        sp_dec_raw    = 1'b0;
        o_pc_load     = 1'b0;
        o_irq_ack     = 1'b0;
        unique case (state_q)
            StIdle, StDrain: begin
                o_mem_addr    = i_pipe_addr;
                o_mem_wdata   = i_pipe_wdata;
                o_mem_en32    = i_pipe_en32;
                // A faulting access must never reach memory.
                o_mem_read    = i_pipe_read && !exc_hit;
                mem_write_raw = i_pipe_write && !exc_hit;
                o_stall       = (state_q == StDrain);
            end
            StPush: begin
                o_stall       = 1'b1;
                o_mem_en32    = 1'b1;
                o_mem_addr    = i_sp;
                o_mem_wdata   = ret_q | {i_flags, 28'd0};
                mem_write_raw = !exc_hit;
                sp_dec_raw    = !exc_hit;
            end
            StVec: begin
                o_stall    = 1'b1;
                o_mem_read = 1'b1;
                o_mem_en32 = 1'b1;
                o_mem_addr = vec_addr;
            end
            StLoad: begin
                o_stall   = 1'b1;
                o_flush   = 1'b1;
                o_pc_load = 1'b1;
                o_irq_ack = (kind_q == KindIrq);
            end
            default: begin
                o_stall = 1'b0;
            end
        endcase
    end

    // Reset cycles may still see a stale state, so stack side effects are gated here.
    assign o_mem_write = mem_write_raw && i_reset_n;
    assign o_sp_dec    = sp_dec_raw && i_reset_n;
    assign o_pc_target = pc_target_q;
    assign o_epc       = epc_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_event_sequencer.sv
// Directed table-driven bench for mem_event_sequencer with a small vector-memory model.
module tb_mem_event_sequencer;

    localparam logic [8:0] B = 9'h100;  // busy
    localparam logic [8:0] S = 9'h080;  // stall
    localparam logic [8:0] F = 9'h040;  // flush
    localparam logic [8:0] R = 9'h020;  // mem read
    localparam logic [8:0] W = 9'h010;  // mem write
    localparam logic [8:0] E = 9'h008;  // mem en32
    localparam logic [8:0] D = 9'h004;  // sp dec
    localparam logic [8:0] L = 9'h002;  // pc load
    localparam logic [8:0] A = 9'h001;  // irq ack

    typedef struct {
        logic        rst_n;
        logic        irq;
        logic        irq_en;
        logic [1:0]  exc;
        logic [31:0] pc;
        logic [3:0]  flags;
        logic        pme;
        logic        prd;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [8:0]  ctl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] tgt;
        logic [31:0] epc;
    } vec_t;

    logic        clk;
    logic        i_reset_n, i_irq, i_irq_en;
    logic [1:0]  i_exc;
    logic [31:0] i_pc, i_sp, i_pipe_addr, i_pipe_wdata, i_mem_rdata;
    logic [3:0]  i_flags;
    logic        i_pipe_mem_en, i_pipe_read, i_pipe_write, i_pipe_en32;
    logic [31:0] o_mem_addr, o_mem_wdata, o_pc_target, o_epc;
    logic        o_mem_read, o_mem_write, o_mem_en32, o_stall, o_flush;
    logic        o_sp_dec, o_pc_load, o_irq_ack, o_busy;

    int checks = 0;
    int failures = 0;
    vec_t tbl [30];

    mem_event_sequencer dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_irq        (i_irq),
        .i_irq_en     (i_irq_en),
        .i_exc        (i_exc),
        .i_pc         (i_pc),
        .i_flags      (i_flags),
        .i_sp         (i_sp),
        .i_pipe_mem_en(i_pipe_mem_en),
        .i_pipe_read  (i_pipe_read),
        .i_pipe_write (i_pipe_write),
        .i_pipe_en32  (i_pipe_en32),
        .i_pipe_addr  (i_pipe_addr),
        .i_pipe_wdata (i_pipe_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_mem_en32   (o_mem_en32),
        .o_stall      (o_stall),
        .o_flush      (o_flush),
        .o_sp_dec     (o_sp_dec),
        .o_pc_load    (o_pc_load),
        .o_pc_target  (o_pc_target),
        .o_epc        (o_epc),
        .o_irq_ack    (o_irq_ack),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table contents: M[2]=0x100, M[4]=0x300, M[6]=0x200.
    assign i_mem_rdata = (o_mem_addr == 32'h2) ? 32'h100 :
                         (o_mem_addr == 32'h4) ? 32'h300 :
                         (o_mem_addr == 32'h6) ? 32'h200 : 32'hDEAD_BEEF;

    function automatic vec_t r(input logic rst_n, input logic irq, input logic irq_en,
                               input logic [1:0] exc, input logic [31:0] pc,
                               input logic [3:0] flags, input logic pme, input logic prd,
                               input logic pwr, input logic [31:0] paddr,
                               input logic [31:0] pwdata, input logic [8:0] ctl,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] tgt, input logic [31:0] epc);
        vec_t v;
        v.rst_n = rst_n; v.irq = irq; v.irq_en = irq_en; v.exc = exc; v.pc = pc;
        v.flags = flags; v.pme = pme; v.prd = prd; v.pwr = pwr; v.paddr = paddr;
        v.pwdata = pwdata; v.ctl = ctl; v.addr = addr; v.wdata = wdata; v.tgt = tgt;
        v.epc = epc;
        return v;
    endfunction

    function automatic logic [136:0] actual();
        return {o_busy, o_stall, o_flush, o_mem_read, o_mem_write, o_mem_en32, o_sp_dec,
                o_pc_load, o_irq_ack, o_mem_addr, o_mem_wdata, o_pc_target, o_epc};
    endfunction

    task automatic drive(input vec_t v);
        i_reset_n     = v.rst_n;
        i_irq         = v.irq;
        i_irq_en      = v.irq_en;
        i_exc         = v.exc;
        i_pc          = v.pc;
        i_flags       = v.flags;
        i_pipe_mem_en = v.pme;
        i_pipe_read   = v.prd;
        i_pipe_write  = v.pwr;
        i_pipe_en32   = v.pme;
        i_pipe_addr   = v.paddr;
        i_pipe_wdata  = v.pwdata;
    endtask

    task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [136:0] exp;
        bit           seen;
        i_sp = 32'h3FE;
        drive(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        // Basic IRQ entry
        tbl[0]  = r(1, 0, 1, 0, 0,     0,   0, 0, 0, 0,     0,       0,            0,      0,             0,      0);
        tbl[1]  = r(1, 0, 1, 0, 0,     0,   1, 0, 1, 'h40,  'h1234,  W|E,          'h40,   'h1234,        0,      0);
        tbl[2]  = r(1, 1, 1, 0, 'h10,  'hA, 0, 0, 0, 0,     0,       0,            0,      0,             0,      0);
        tbl[3]  = r(1, 1, 1, 0, 'h10,  'hA, 0, 0, 0, 0,     0,       B|S,          0,      0,             0,      0);
        tbl[4]  = r(1, 1, 1, 0, 'h10,  'hA, 0, 0, 0, 0,     0,       B|S|W|E|D,    'h3FE,  'hA000_0010,   0,      0);
        tbl[5]  = r(1, 1, 1, 0, 'h10,  'hA, 0, 0, 0, 0,     0,       B|S|R|E,      'h2,    0,             0,      0);
        tbl[6]  = r(1, 0, 1, 0, 'h10,  'hA, 0, 0, 0, 0,     0,       B|S|F|L|A,    0,      0,             'h100,  0);
        tbl[7]  = r(1, 0, 1, 0, 0,     0,   0, 0, 0, 0,     0,       0,            0,      0,             'h100,  0);
        // Drain three pipeline accesses before pushing
        tbl[8]  = r(1, 1, 1, 0, 'h30,  0,   1, 0, 1, 'h50,  'h55,    W|E,          'h50,   'h55,          'h100,  0);
        tbl[9]  = r(1, 1, 1, 0, 'h30,  0,   1, 0, 1, 'h52,  'h66,    B|S|W|E,      'h52,   'h66,          'h100,  0);
        tbl[10] = r(1, 1, 1, 0, 'h30,  0,   1, 1, 0, 'h54,  0,       B|S|R|E,      'h54,   0,             'h100,  0);
        tbl[11] = r(1, 1, 1, 0, 'h30,  0,   1, 0, 1, 'h56,  'h77,    B|S|W|E,      'h56,   'h77,          'h100,  0);
        tbl[12] = r(1, 1, 1, 0, 'h30,  0,   0, 0, 0, 0,     0,       B|S,          0,      0,             'h100,  0);
        tbl[13] = r(1, 0, 1, 0, 'h30,  0,   0, 0, 0, 0,     0,       B|S|W|E|D,    'h3FE,  'h30,          'h100,  0);
        tbl[14] = r(1, 0, 1, 0, 'h30,  0,   0, 0, 0, 0,     0,       B|S|R|E,      'h2,    0,             'h100,  0);
        tbl[15] = r(1, 0, 1, 0, 'h30,  0,   0, 0, 0, 0,     0,       B|S|F|L|A,    0,      0,             'h100,  0);
        // Exception kills a pending pipeline write
        tbl[16] = r(1, 0, 1, 2, 'h20,  0,   1, 0, 1, 'h60,  'h99,    E,            'h60,   'h99,          'h100,  0);
        tbl[17] = r(1, 0, 1, 0, 'h20,  0,   0, 0, 0, 0,     0,       B|S|R|E,      'h6,    0,             'h100,  'h20);
        tbl[18] = r(1, 0, 1, 0, 'h20,  0,   0, 0, 0, 0,     0,       B|S|F|L,      0,      0,             'h200,  'h20);
        tbl[19] = r(1, 0, 1, 0, 0,     0,   0, 0, 0, 0,     0,       0,            0,      0,             'h200,  'h20);
        // Exception wins over simultaneous IRQ, IRQ follows after LOAD
        tbl[20] = r(1, 1, 1, 1, 'h70,  0,   0, 0, 0, 0,     0,       0,            0,      0,             'h200,  'h20);
        tbl[21] = r(1, 1, 1, 0, 'h70,  0,   0, 0, 0, 0,     0,       B|S|R|E,      'h4,    0,             'h200,  'h70);
        tbl[22] = r(1, 1, 1, 0, 'h70,  0,   0, 0, 0, 0,     0,       B|S|F|L,      0,      0,             'h300,  'h70);
        tbl[23] = r(1, 1, 1, 0, 'h80,  0,   0, 0, 0, 0,     0,       0,            0,      0,             'h300,  'h70);
        tbl[24] = r(1, 1, 1, 0, 'h80,  0,   0, 0, 0, 0,     0,       B|S,          0,      0,             'h300,  'h70);
        // Stack overflow during PUSH
        tbl[25] = r(1, 1, 1, 1, 'h80,  0,   0, 0, 0, 0,     0,       B|S|E,        'h3FE,  'h80,          'h300,  'h70);
        tbl[26] = r(1, 0, 1, 0, 'h80,  0,   0, 0, 0, 0,     0,       B|S|R|E,      'h4,    0,             'h300,  'h80);
        tbl[27] = r(1, 0, 1, 0, 'h80,  0,   0, 0, 0, 0,     0,       B|S|F|L,      0,      0,             'h300,  'h80);
        // Disabled interrupts are ignored
        tbl[28] = r(1, 1, 0, 0, 'h90,  0,   0, 0, 0, 0,     0,       0,            0,      0,             'h300,  'h80);
        tbl[29] = r(1, 1, 0, 0, 'h90,  0,   0, 0, 0, 0,     0,       0,            0,      0,             'h300,  'h80);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            exp = {tbl[i].ctl, tbl[i].addr, tbl[i].wdata, tbl[i].tgt, tbl[i].epc};
            check($sformatf("row%0d", i), actual(), exp);
        end

        // Reset asserted while the sequencer sits in PUSH
        @(negedge clk);
        drive(r(1, 1, 1, 0, 'h90, 'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (o_sp_dec) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL push_timeout: got no PUSH within 8 cycles, required PUSH");
        end
        drive(r(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_no_write", {135'd0, o_mem_write, o_sp_dec}, 137'd0);
        @(negedge clk);
        drive(r(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_idle", actual(), 137'd0);
        @(negedge clk);
        #1;
        check("rst_quiet", actual(), 137'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
